iter_alu: RTL and testbench

- Parametrised, multi-cycle successor to the single-cycle execute ALU.
- Covers the base integer ops (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND) plus the M-extension ops (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
- Optional 32-bit word mode for the RV64 *W instructions.
- Sits in the execute stage behind a valid/ready handshake, so the pipeline stalls while an iterative multiply or divide is in flight; a flush input aborts in-flight work.

---
 rtl/iter_alu_pkg.sv | 61 ++++++
 rtl/iter_alu_if.sv | 28 ++
 rtl/iter_alu_base.sv | 36 +++
 rtl/iter_alu.sv | 158 +++++++++++++++
 tb/tb_iter_alu.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/iter_alu_pkg.sv
// Shared op codes, FSM states and op-class helpers for the iterative execute ALU.
package iter_alu_pkg;

  localparam int unsigned OP_W = 5;

  typedef enum logic [OP_W-1:0] {
    OP_ADD    = 5'd0,
    OP_SUB    = 5'd1,
    OP_SLL    = 5'd2,
    OP_SLT    = 5'd3,
    OP_SLTU   = 5'd4,
    OP_XOR    = 5'd5,
    OP_SRL    = 5'd6,
    OP_SRA    = 5'd7,
    OP_OR     = 5'd8,
    OP_AND    = 5'd9,
    OP_MUL    = 5'd16,
    OP_MULH   = 5'd17,
    OP_MULHSU = 5'd18,
    OP_MULHU  = 5'd19,
    OP_DIV    = 5'd20,
    OP_DIVU   = 5'd21,
    OP_REM    = 5'd22,
    OP_REMU   = 5'd23
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // MUL* occupy codes 16..19, DIV/REM* occupy 20..23
  function automatic logic is_mul(input logic [OP_W-1:0] op);
    return op[4:2] == 3'b100;
  endfunction

  function automatic logic is_div(input logic [OP_W-1:0] op);
    return op[4:2] == 3'b101;
  endfunction

  function automatic logic is_rem(input logic [OP_W-1:0] op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

  function automatic logic is_sdiv(input logic [OP_W-1:0] op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  // Operands treated as unsigned (zero-extended in word mode, never negated)
  function automatic logic is_a_unsigned(input logic [OP_W-1:0] op);
    return (op == OP_SRL) || (op == OP_SLTU) || (op == OP_MULHU) ||
           (op == OP_DIVU) || (op == OP_REMU);
  endfunction

  function automatic logic is_b_unsigned(input logic [OP_W-1:0] op);
    return is_a_unsigned(op) || (op == OP_MULHSU);
  endfunction

endpackage

// File: rtl/iter_alu_if.sv
// Execute-stage request/response handshake bundle for iter_alu.
interface iter_alu_if #(
  parameter int unsigned XLEN = 64
);
  import iter_alu_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [OP_W-1:0] op;
  logic            word;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] res;
  logic            zero;

  modport master (
    output in_valid, op, word, a, b, out_ready,
    input  in_ready, out_valid, res, zero
  );

  modport slave (
    input  in_valid, op, word, a, b, out_ready,
    output in_ready, out_valid, res, zero
  );

endinterface

// File: rtl/iter_alu_base.sv
// Single-cycle base integer datapath; operands arrive already word-extended.
module iter_alu_base
  import iter_alu_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [OP_W-1:0] op_i,
  input  logic            word_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] res_c_o
);

  localparam int unsigned SHW = $clog2(XLEN);

  logic [SHW-1:0] sh;

  always_comb begin
    sh      = word_i ? SHW'(b_i[4:0]) : b_i[SHW-1:0];
    res_c_o = '0;
    case (op_i)
      OP_ADD:  res_c_o = a_i + b_i;
      OP_SUB:  res_c_o = a_i - b_i;
      OP_SLL:  res_c_o = a_i << sh;
      OP_SLT:  res_c_o = XLEN'($signed(a_i) < $signed(b_i));
      OP_SLTU: res_c_o = XLEN'(a_i < b_i);
      OP_XOR:  res_c_o = a_i ^ b_i;
      OP_SRL:  res_c_o = a_i >> sh;
      OP_SRA:  res_c_o = XLEN'($signed(a_i) >>> sh);
      OP_OR:   res_c_o = a_i | b_i;
      OP_AND:  res_c_o = a_i & b_i;
      default: res_c_o = '0;
    endcase
  end

endmodule

// File: rtl/iter_alu.sv
// Multi-cycle execute ALU: base ops in one cycle, shift-add MUL and restoring DIV
// over XLEN iterations on operand magnitudes, with sign fix-up in the last step.
module iter_alu
  import iter_alu_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  iter_alu_if.slave   bus
);

  localparam int unsigned SHW = $clog2(XLEN);
  localparam int unsigned WSH = XLEN - 32;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
    logic [XLEN-1:0] t;
    t = v << WSH;
    return XLEN'($signed(t) >>> WSH);
  endfunction

  function automatic logic [XLEN-1:0] zext32(input logic [XLEN-1:0] v);
    logic [XLEN-1:0] t;
    t = v << WSH;
    return t >> WSH;
  endfunction

  state_e          state_q;
  logic [XLEN-1:0] res_q, hi_q, lo_q, dvs_q;
  logic            zero_q, wm_q, neg_q, neg_rem_q;
  logic [OP_W-1:0] op_q;
  logic [SHW-1:0]  cnt_q;

  logic            wm, a_uns, b_uns, sa, sb, div0, ovf, accept;
  logic            start_mul, start_div;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, base_res, quick, quick_fin;

  assign wm = (XLEN == 64) && bus.word;

  // Operand conditioning on accept: word extension, magnitudes, special divides
  always_comb begin
    a_uns = is_a_unsigned(bus.op);
    b_uns = is_b_unsigned(bus.op);
    a_ext = wm ? (a_uns ? zext32(bus.a) : sext32(bus.a)) : bus.a;
    b_ext = wm ? (b_uns ? zext32(bus.b) : sext32(bus.b)) : bus.b;
    sa    = !a_uns && a_ext[XLEN-1];
    sb    = !b_uns && b_ext[XLEN-1];
    a_mag = sa ? -a_ext : a_ext;
    b_mag = sb ? -b_ext : b_ext;
    div0  = (b_ext == '0);
    ovf   = is_sdiv(bus.op) &&
            (wm ? ((bus.a[31:0] == 32'h8000_0000) && (bus.b[31:0] == 32'hFFFF_FFFF))
                : ((bus.a == MIN_NEG) && (bus.b == '1)));
    start_mul = is_mul(bus.op);
    start_div = is_div(bus.op) && !div0 && !ovf;
    if (is_div(bus.op) && div0) begin
      quick = is_rem(bus.op) ? a_ext : '1;
    end else if (ovf) begin
      quick = is_rem(bus.op) ? '0 : a_ext;
    end else begin
      quick = base_res;
    end
    quick_fin = wm ? sext32(quick) : quick;
  end

  iter_alu_base #(.XLEN(XLEN)) u_base (
    .op_i    (bus.op),
    .word_i  (wm),
    .a_i     (a_ext),
    .b_i     (b_ext),
    .res_c_o (base_res)
  );

  logic [XLEN:0]     mul_sum, div_t;
  logic [XLEN-1:0]   mul_hi, mul_lo, div_hi, div_lo, div_diff, mul_res, div_res;
  logic [XLEN-1:0]   iter_res, iter_fin;
  logic [2*XLEN-1:0] prod, prod_f;
  logic              div_ge, last;

  // One iteration step of each engine, plus the final-cycle sign fix-up
  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dvs_q} : '0);
    mul_hi   = mul_sum[XLEN:1];
    mul_lo   = {mul_sum[0], lo_q[XLEN-1:1]};
    prod     = {mul_hi, mul_lo};
    prod_f   = neg_q ? -prod : prod;
    mul_res  = (op_q == OP_MUL) ? prod_f[XLEN-1:0] : prod_f[2*XLEN-1:XLEN];

    div_t    = {hi_q, lo_q[XLEN-1]};
    div_ge   = (div_t >= {1'b0, dvs_q});
    div_diff = div_t[XLEN-1:0] - dvs_q;
    div_hi   = div_ge ? div_diff : div_t[XLEN-1:0];
    div_lo   = {lo_q[XLEN-2:0], div_ge};
    div_res  = is_rem(op_q) ? (neg_rem_q ? -div_hi : div_hi)
                            : (neg_q ? -div_lo : div_lo);

    iter_res = (state_q == S_MUL) ? mul_res : div_res;
    iter_fin = wm_q ? sext32(iter_res) : iter_res;
    last     = (cnt_q == SHW'(XLEN - 1));
  end

  assign bus.in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && bus.out_ready);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.res       = res_q;
  assign bus.zero      = zero_q;
  assign accept        = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state_q <= S_IDLE;
      res_q   <= '0;
      zero_q  <= 1'b1;
    end else begin
      case (state_q)
        S_MUL, S_DIV: begin
          hi_q  <= (state_q == S_MUL) ? mul_hi : div_hi;
          lo_q  <= (state_q == S_MUL) ? mul_lo : div_lo;
          cnt_q <= cnt_q + SHW'(1);
          if (last) begin
            res_q   <= iter_fin;
            zero_q  <= (iter_fin == '0);
            state_q <= S_DONE;
          end
        end
        S_DONE: if (bus.out_ready) state_q <= S_IDLE;
        default: ;
      endcase

      // An accept in DONE retires the held result and overrides the return to IDLE
      if (accept) begin
        op_q  <= bus.op;
        wm_q  <= wm;
        cnt_q <= '0;
        if (start_mul) begin
          hi_q    <= '0;
          lo_q    <= b_mag;
          dvs_q   <= a_mag;
          neg_q   <= sa ^ sb;
          state_q <= S_MUL;
        end else if (start_div) begin
          hi_q      <= '0;
          lo_q      <= a_mag;
          dvs_q     <= b_mag;
          neg_q     <= sa ^ sb;
          neg_rem_q <= sa;
          state_q   <= S_DIV;
        end else begin
          res_q   <= quick_fin;
          zero_q  <= (quick_fin == '0);
          state_q <= S_DONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_iter_alu.sv
// Directed-vector bench for iter_alu at XLEN=64 with hand-computed expectations.
module tb_iter_alu;
  import iter_alu_pkg::*;

  localparam int unsigned XLEN = 64;
  localparam int MAX_LAT = 200;

  logic clk = 1'b0;
  logic rst, flush;
  int   n_vec = 0;
  int   n_err = 0;

  iter_alu_if #(.XLEN(XLEN)) bus ();

  iter_alu #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Offer one op with out_ready=1, then check latency, result, zero and retirement
  task automatic run(input string tag, input logic [4:0] op, input logic word,
                     input logic [63:0] a, input logic [63:0] b,
                     input logic [63:0] exp_res, input int exp_lat);
    int   lat;
    logic rdy_busy;
    bus.in_valid  = 1'b1;
    bus.op        = op;
    bus.word      = word;
    bus.a         = a;
    bus.b         = b;
    bus.out_ready = 1'b1;
    chk({tag, ".in_ready"}, 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat      = 1;
    rdy_busy = 1'b0;
    while (!bus.out_valid && lat < MAX_LAT) begin
      rdy_busy |= bus.in_ready;
      @(negedge clk);
      lat++;
    end
    chk({tag, ".lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, ".res"}, bus.res, exp_res);
    chk({tag, ".zero"}, 64'(bus.zero), 64'(exp_res == 64'd0));
    if (exp_lat > 1) chk({tag, ".busy_rdy"}, 64'(rdy_busy), 64'd0);
    @(negedge clk);
    chk({tag, ".retire"}, 64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    int   lat;
    logic seen;
    rst = 1'b1;
    flush = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op        = 5'd0;
    bus.word      = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst.out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst.in_ready",  64'(bus.in_ready),  64'd1);
    chk("rst.res",       bus.res,            64'd0);
    chk("rst.zero",      64'(bus.zero),      64'd1);

    // ADD then back-to-back SUB accepted in the DONE cycle
    bus.in_valid = 1'b1; bus.op = OP_ADD; bus.a = 64'd5; bus.b = 64'hFFFF_FFFF_FFFF_FFFD;
    @(negedge clk);
    chk("add.out_valid", 64'(bus.out_valid), 64'd1);
    chk("add.res",       bus.res,            64'd2);
    chk("add.zero",      64'(bus.zero),      64'd0);
    chk("b2b.in_ready",  64'(bus.in_ready),  64'd1);
    bus.op = OP_SUB; bus.a = 64'd7; bus.b = 64'd7;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("sub.out_valid", 64'(bus.out_valid), 64'd1);
    chk("sub.res",       bus.res,            64'd0);
    chk("sub.zero",      64'(bus.zero),      64'd1);
    @(negedge clk);
    chk("sub.retire",    64'(bus.out_valid), 64'd0);

    run("mulh",   OP_MULH,   1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    run("mulhu",  OP_MULHU,  1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 65);
    run("mul",    OP_MUL,    1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65);
    run("mulhsu", OP_MULHSU, 1'b0, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    run("div",    OP_DIV,    1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    run("rem",    OP_REM,    1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    run("divu",   OP_DIVU,   1'b0, 64'd100, 64'd7, 64'd14, 65);
    run("remu",   OP_REMU,   1'b0, 64'd100, 64'd7, 64'd2, 65);
    run("divu0",  OP_DIVU,   1'b0, 64'd7, 64'd0, '1, 1);
    run("remu0",  OP_REMU,   1'b0, 64'd7, 64'd0, 64'd7, 1);
    run("divovf", OP_DIV,    1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1);
    run("removf", OP_REM,    1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 1);
    run("addw",   OP_ADD,    1'b1, 64'h7FFF_FFFF, 64'd1, 64'hFFFF_FFFF_8000_0000, 1);
    run("sraw",   OP_SRA,    1'b1, 64'h8000_0000, 64'h21, 64'hFFFF_FFFF_C000_0000, 1);
    run("divw",   OP_DIV,    1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    run("slt",    OP_SLT,    1'b0, '1, 64'd1, 64'd1, 1);
    run("sltu",   OP_SLTU,   1'b0, '1, 64'd1, 64'd0, 1);
    run("srl",    OP_SRL,    1'b0, 64'h8000_0000_0000_0000, 64'd63, 64'd1, 1);
    run("sll",    OP_SLL,    1'b0, 64'd1, 64'h44, 64'd16, 1);
    run("illegal", 5'd10,    1'b0, 64'd3, 64'd4, 64'd0, 1);

    // Backpressure: completed MUL held while out_ready=0
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.op = OP_MUL; bus.word = 1'b0; bus.a = 64'd6; bus.b = 64'd7;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < MAX_LAT) begin
      @(negedge clk);
      lat++;
    end
    chk("bp.lat", 64'(lat), 64'd65);
    for (int i = 0; i < 5; i++) begin
      chk("bp.res", bus.res, 64'd42);
      chk("bp.in_ready", 64'(bus.in_ready), 64'd0);
      chk("bp.out_valid", 64'(bus.out_valid), 64'd1);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp.retire", 64'(bus.out_valid), 64'd0);
    chk("bp.idle_rdy", 64'(bus.in_ready), 64'd1);

    // Flush at N+10 of a DIV
    run("pre_flush", OP_ADD, 1'b0, 64'd1, 64'd1, 64'd2, 1);
    bus.in_valid = 1'b1; bus.op = OP_DIVU; bus.a = 64'd100; bus.b = 64'd7;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush.out_valid", 64'(bus.out_valid), 64'd0);
    chk("flush.in_ready",  64'(bus.in_ready),  64'd1);
    chk("flush.res",       bus.res,            64'd0);
    chk("flush.zero",      64'(bus.zero),      64'd1);
    seen = 1'b0;
    repeat (80) begin
      seen |= bus.out_valid;
      @(negedge clk);
    end
    chk("flush.stale", 64'(seen), 64'd0);

    // Reset in the middle of a MUL
    run("pre_rst", OP_ADD, 1'b0, 64'd1, 64'd1, 64'd2, 1);
    bus.in_valid = 1'b1; bus.op = OP_MUL; bus.a = 64'd3; bus.b = 64'd5;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid.out_valid", 64'(bus.out_valid), 64'd0);
    chk("rstmid.in_ready",  64'(bus.in_ready),  64'd1);
    chk("rstmid.res",       bus.res,            64'd0);
    chk("rstmid.zero",      64'(bus.zero),      64'd1);
    seen = 1'b0;
    repeat (80) begin
      seen |= bus.out_valid;
      @(negedge clk);
    end
    chk("rstmid.stale", 64'(seen), 64'd0);

    run("post", OP_XOR, 1'b0, 64'hF0F0, 64'h0FF0, 64'hFF00, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
